// File: rtl/demux_decode.sv
// demux_decode: registered 1-to-N stream demultiplexer.
// One beat per cycle enters on a valid/ready input together with a select
// vector. The highest set select bit picks the target port (same priority rule
// as the upstream priority mux); the beat parks in that port's one-deep slot.
// Each port drains under its own valid/ready, so a stalled port only blocks
// beats aimed at it. An all-zero select drops the beat and bumps drop_cnt.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous clear of all slot valids; blocks input
//   in_valid/in_ready input handshake; in_ready never looks at in_valid
//   in_data, in_sel   payload and select vector (highest set bit wins)
//   out_valid/ready   per-port handshake
//   out_data          port i payload at [i*DATA_W +: DATA_W]
//   drop_cnt          saturating count of beats dropped for zero select
//   busy              OR of out_valid

// One output slot: valid bit plus payload register.
module demux_decode_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              fill,     // accepted beat targets this slot
  input  logic [DATA_W-1:0] din,
  input  logic              ready,    // consumer accepts
  output logic              vld_o,
  output logic [DATA_W-1:0] data_o
);
  logic              vld_q, vld_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Fill beats drain, so a same-cycle drain+fill keeps the slot full.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (flush)              vld_d = 1'b0;
    else if (fill)          vld_d = 1'b1;
    else if (vld_q & ready) vld_d = 1'b0;
    if (fill) data_d = din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;
endmodule

module demux_decode #(
  parameter int DATA_W  = 8,
  parameter int N_PORTS = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  input  logic [N_PORTS-1:0]        in_sel,
  output logic [N_PORTS-1:0]        out_valid,
  input  logic [N_PORTS-1:0]        out_ready,
  output logic [N_PORTS*DATA_W-1:0] out_data,
  output logic [15:0]               drop_cnt,
  output logic                      busy
);
  logic [N_PORTS-1:0]             sel_oh;
  logic                           sel_none;
  logic                           tgt_free;
  logic                           accept;
  logic [N_PORTS-1:0][DATA_W-1:0] slot_data;
  logic [15:0]                    drop_q, drop_d;

  // Highest set bit wins: later (higher) hits overwrite earlier ones.
  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (in_sel[i]) begin
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
      end
    end
  end

  assign sel_none = ~|in_sel;
  // Target slot can take a beat if empty or draining this cycle.
  assign tgt_free = |(sel_oh & (~out_valid | out_ready));
  assign in_ready = ~flush & (sel_none | tgt_free);
  assign accept   = in_valid & in_ready;

  for (genvar g = 0; g < N_PORTS; g++) begin : g_slot
    demux_decode_slot #(.DATA_W(DATA_W)) u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .flush  (flush),
      .fill   (accept & sel_oh[g]),
      .din    (in_data),
      .ready  (out_ready[g]),
      .vld_o  (out_valid[g]),
      .data_o (slot_data[g])
    );
  end

  assign out_data = slot_data;
  assign busy     = |out_valid;

  // Saturating drop counter; flush already blocks accept.
  always_comb begin
    drop_d = drop_q;
    if (accept & sel_none & ~&drop_q) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_q <= '0;
    else        drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;
endmodule

// File: tb/tb_demux_decode.sv
// Scoreboard bench for demux_decode: accepted beats are pushed into a
// per-port expected queue, popped and compared when the port handshakes.
module tb_demux_decode;
  localparam int DW = 8;
  localparam int NP = 8;

  logic             clk, rst_n, flush, in_valid, in_ready, busy;
  logic [DW-1:0]    in_data;
  logic [NP-1:0]    in_sel, out_valid, out_ready;
  logic [NP*DW-1:0] out_data;
  logic [15:0]      drop_cnt;

  demux_decode #(.DATA_W(DW), .N_PORTS(NP)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .drop_cnt(drop_cnt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  logic [7:0]  sb [NP][$];
  logic [15:0] exp_drop = 16'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int top_bit(input logic [NP-1:0] s);
    int t = -1;
    for (int i = 0; i < NP; i++) if (s[i]) t = i;
    return t;
  endfunction

  function automatic logic [NP-1:0] model_vld();
    logic [NP-1:0] v = '0;
    for (int i = 0; i < NP; i++) v[i] = (sb[i].size() != 0);
    return v;
  endfunction

  function automatic logic [7:0] port(input int i);
    return out_data[i*DW +: DW];
  endfunction

  // One clock: compare outputs at negedge against the model, update the
  // model for the coming edge, then return #1 after the rising edge.
  task automatic step();
    int            t;
    logic          exp_rdy;
    logic [NP-1:0] mv;
    @(negedge clk);
    mv = model_vld();
    t  = top_bit(in_sel);
    exp_rdy = !flush && (t < 0 || !mv[t] || out_ready[t]);
    check("out_valid", out_valid, mv);
    check("busy", busy, |mv);
    check("in_ready", in_ready, exp_rdy);
    check("drop_cnt", drop_cnt, exp_drop);
    for (int i = 0; i < NP; i++) begin
      if (out_valid[i] && out_ready[i]) begin
        if (sb[i].size() == 0) check($sformatf("spurious_p%0d", i), 1, 0);
        else check($sformatf("data_p%0d", i), port(i), sb[i].pop_front());
      end
    end
    if (in_valid && exp_rdy) begin
      if (t < 0) begin
        if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
      end else sb[t].push_back(in_data);
    end
    if (flush) for (int i = 0; i < NP; i++) sb[i].delete();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [NP-1:0] s, input logic [7:0] d);
    in_valid = 1'b1; in_sel = s; in_data = d;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    in_sel = '0; out_ready = '1;
    #12;
    check("rst_vld", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1; rst_n = 1'b1;

    // Route
    beat(8'h04, 8'hA5);
    check("route_vld", out_valid, 8'h04);
    check("route_data", port(2), 8'hA5);
    step();
    check("route_empty", out_valid, 8'h00);

    // Priority decode
    beat(8'h81, 8'h3C);
    check("prio_vld", out_valid, 8'h80);
    check("prio_data", port(7), 8'h3C);
    beat(8'h06, 8'h5A);
    check("prio2_vld", out_valid, 8'h04);
    check("prio2_data", port(2), 8'h5A);
    step();

    // Backpressure on port 5; port-1 beat sits behind the held 8'h22
    out_ready = 8'hDF;
    beat(8'h20, 8'h11);
    in_valid = 1'b1; in_sel = 8'h20; in_data = 8'h22;
    #1 check("bp_in_ready", in_ready, 0);
    step(); step();
    check("bp_held_data", port(5), 8'h11);
    out_ready = 8'hFF;
    #1 check("bp_release_rdy", in_ready, 1);
    step();
    check("bp_second_data", port(5), 8'h22);
    check("bp_second_vld", out_valid, 8'h20);
    beat(8'h02, 8'h33);
    check("bp_p1_vld", out_valid, 8'h02);
    step();

    // Simultaneous drain and fill on port 3
    out_ready = 8'hF7;
    beat(8'h08, 8'h44);
    out_ready = 8'hFF;
    in_valid = 1'b1; in_sel = 8'h08; in_data = 8'h77;
    #1 check("df_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("df_vld", out_valid, 8'h08);
    check("df_data", port(3), 8'h77);
    step();

    // Drops with a parked beat on port 0
    out_ready = 8'hFE;
    beat(8'h01, 8'hC0);
    repeat (3) beat(8'h00, 8'hFF);
    check("drop3_cnt", drop_cnt, 3);
    check("drop3_vld", out_valid, 8'h01);
    out_ready = 8'hFF;
    step();

    // Flush with slots 0, 4, 6 full
    out_ready = 8'h00;
    beat(8'h01, 8'hD0);
    beat(8'h10, 8'hD4);
    beat(8'h40, 8'hD6);
    check("fl_pre_vld", out_valid, 8'h51);
    flush = 1'b1; in_valid = 1'b1; in_sel = 8'h02; in_data = 8'h99;
    #1 check("fl_in_ready", in_ready, 0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_vld", out_valid, 8'h00);
    check("fl_drop", drop_cnt, 3);
    check("fl_data4", port(4), 8'hD4);
    check("fl_data1", port(1), 8'h33);
    step();

    // Saturation
    out_ready = 8'hFF;
    in_valid = 1'b1; in_sel = 8'h00;
    repeat (65538) @(posedge clk);
    #1;
    exp_drop = 16'hFFFF;
    check("sat_cnt", drop_cnt, 16'hFFFF);
    step();
    check("sat_hold", drop_cnt, 16'hFFFF);
    in_valid = 1'b0;

    // Asynchronous reset mid-operation
    out_ready = 8'h00;
    beat(8'h01, 8'hE0);
    beat(8'h10, 8'hE4);
    beat(8'h40, 8'hE6);
    check("ar_pre_vld", out_valid, 8'h51);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("ar_vld", out_valid, 0);
    check("ar_data", out_data, 0);
    check("ar_drop", drop_cnt, 0);
    check("ar_busy", busy, 0);
    check("ar_in_ready", in_ready, 1);
    for (int i = 0; i < NP; i++) sb[i].delete();
    exp_drop = 16'd0;
    @(posedge clk); #1; rst_n = 1'b1;
    out_ready = 8'hFF;
    beat(8'h10, 8'hEE);
    check("post_rst_data", port(4), 8'hEE);
    step();

    for (int i = 0; i < NP; i++) check($sformatf("sb_empty_p%0d", i), sb[i].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/demux_decode.md
# demux_decode

Registered 1-to-8 stream demultiplexer: the distribution side of the 8-input priority mux in the datapath. It accepts one beat per cycle on a valid/ready input with a select vector, decodes the select with the same priority rule as the mux (highest set bit wins), and parks the beat in a one-deep output slot for the chosen port. Each port drains independently under its own valid/ready handshake, so a stalled port does not block traffic to the others.

## Interface
- DATA_W, 8, data width per beat
- N_PORTS, 8, number of output ports; fixed at 8 for this release
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of all output slots
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_data  in  DATA_W  input payload
- in_sel  in  N_PORTS  select vector; highest set bit selects the target port
- out_valid  out  N_PORTS  bit i: slot i holds a beat
- out_ready  in  N_PORTS  bit i: port i consumer accepts
- out_data  out  N_PORTS*DATA_W  port i payload at bits [i*DATA_W +: DATA_W]
- drop_cnt  out  16  saturating count of beats dropped because in_sel was zero
- busy  out  1  OR of out_valid

## Operation
- Target t = index of the highest set bit of in_sel; all-zero in_sel is the "none" target.
- Slot i holds one valid bit and one DATA_W register.
- in_ready rules:
  - Target t: in_ready = !out_valid[t] | out_ready[t].
  - None target: in_ready = 1.
  - flush = 1: in_ready = 0.
  - in_ready depends combinationally on in_sel, out_valid and out_ready; it never depends on in_valid.
- Accepted beat to target t: slot t loads in_data, out_valid[t] = 1 next cycle.
- Accepted beat with none target: no slot is written; drop_cnt increments and saturates at 16'hFFFF.
- Port i drain: when out_valid[i] & out_ready[i], out_valid[i] clears next cycle, unless slot i is refilled in the same cycle.
- Same cycle drain and fill of slot t: out_valid[t] stays 1 and out_data for port t takes the new beat.
- Only the targeted slot can change on input acceptance. Other slots change only by their own drain.
- out_data of an empty slot holds its last value and is don't-care to consumers.
- flush:
  - All out_valid clear next cycle.
  - Data registers and drop_cnt are unchanged.
  - An in_valid beat in the flush cycle is not accepted.
- busy = |out_valid, combinational from the slot valid registers.

## Timing
- Reset (rst_n low, asynchronous): out_valid = 0, all out_data = 0, drop_cnt = 0, busy = 0.
- While rst_n is low, in_ready follows its rule with out_valid = 0: 1 unless flush.
- Reset mid-operation discards all parked beats immediately. No output handshake completes while rst_n is low.
- Latency: a beat accepted in cycle n is on out_data / out_valid[t] in cycle n+1.
- Throughput: one beat per cycle to a single port while that port holds out_ready = 1. Back-to-back beats to different ports are also one per cycle.
- Stalled port t with slot full: any beat targeting t waits with in_ready = 0. Beats are in order on a single input, so this head-of-line stall is intended.
- Once asserted, out_valid[i] and that port's out_data stay stable until the handshake completes or flush/reset occurs.

## Test plan
- Reset then route: in_sel=8'h04, in_data=8'hA5, out_ready=8'hFF -> next cycle out_valid=8'h04, port 2 data=8'hA5; cycle after, out_valid=0.
- Priority decode: in_sel=8'h81, in_data=8'h3C -> only port 7 receives 8'h3C; in_sel=8'h06 -> only port 2.
- Backpressure: out_ready[5]=0, two beats to port 5 (8'h11, 8'h22) -> first parked; in_ready=0 on second. Raising out_ready[5] -> 8'h11 drains, then 8'h22 lands; beat to port 1 while port 5 is stalled also blocks, as it sits behind in order.
- Simultaneous drain/fill: port 3 full with out_ready[3]=1, new beat 8'h77 to port 3 -> in_ready=1, out_valid[3] stays 1, data becomes 8'h77, no bubble.
- Drops and saturation:
  - 3 beats with in_sel=0 -> drop_cnt=3, out_valid unchanged.
  - Preload via 65538 drops -> drop_cnt holds 16'hFFFF.
- Flush/reset mid-operation: slots 0, 4, 6 full, flush=1 with in_valid to port 1 -> in_ready=0, next cycle out_valid=0, drop_cnt unchanged. Repeating with rst_n pulsed low mid-cycle -> outputs zero asynchronously.
